trena_multicanal: RTL



---
 rtl/trena_pkg.sv | 33 +++
 rtl/bcd_contador_sat.sv | 45 ++++
 rtl/trena_multicanal.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/trena_pkg.sv
// rtl/trena_pkg.sv - shared state codes, timing defaults and width helpers for trena_multicanal
package trena_pkg;

    localparam int DB_W = 4;

    // Codes are visible on db_estado and shown on the hexa7seg of the top level.
    typedef enum logic [DB_W-1:0] {
        OCIOSO      = 4'd0,
        PREPARA     = 4'd1,
        DISPARA     = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDE        = 4'd4,
        ARMAZENA    = 4'd5,
        INTERVALO   = 4'd6,
        FIM         = 4'd7
    } estado_t;

    // Defaults for a 50 MHz clock.
    localparam int TRIG_CYCLES_DEF    = 500;
    localparam int CM_CYCLES_DEF      = 2941;
    localparam int TIMEOUT_CYCLES_DEF = 1500000;
    localparam int GAP_CYCLES_DEF     = 3000000;

    // Bits needed to index n items; never less than one bit.
    function automatic int largura_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int maior(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_contador_sat.sv
// rtl/bcd_contador_sat.sv - DIGITS-digit BCD up-counter that saturates at all nines
// Ports: clock, reset (async active-low), limpa (sync clear), habilita (count enable),
//        contagem[4*DIGITS] (digit 0 in [3:0]).
module bcd_contador_sat #(
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  limpa,
    input  logic                  habilita,
    output logic [4*DIGITS-1:0]   contagem
);

    localparam logic [4*DIGITS-1:0] NOVES = {DIGITS{4'h9}};

    logic [4*DIGITS-1:0] proximo;
    logic                vai_um;

    // Ripple a decimal carry from digit 0 upwards.
    always_comb begin
        proximo = contagem;
        vai_um  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (vai_um) begin
                if (contagem[4*d +: 4] == 4'd9) begin
                    proximo[4*d +: 4] = 4'd0;
                end else begin
                    proximo[4*d +: 4] = contagem[4*d +: 4] + 4'd1;
                    vai_um            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (habilita && (contagem != NOVES)) begin
            contagem <= proximo;
        end
    end

endmodule

// File: rtl/trena_multicanal.sv
// rtl/trena_multicanal.sv - round-robin HC-SR04 ranging over NUM_CH sensors, BCD cm result per channel
// Ports: clock, reset (async active-low), mensurar (start sweep), continuo (repeat sweeps),
//        echo[NUM_CH] (async sensor echoes), trigger[NUM_CH] (one-hot while firing),
//        medida[4*DIGITS] (BCD cm), canal, medida_valida (1-cycle), erro (timed out),
//        pronto (1-cycle end of sweep), ocupado, db_estado[4] (state code).
// Optional: define TRENA_TIMEOUT_EN to build the echo watchdog (TIMEOUT_CYCLES).
module trena_multicanal
    import trena_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DIGITS         = 3,
    parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
    parameter int CM_CYCLES      = CM_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              mensurar,
    input  logic                              continuo,
    input  logic [NUM_CH-1:0]                 echo,
    output logic [NUM_CH-1:0]                 trigger,
    output logic [4*DIGITS-1:0]               medida,
    output logic [largura_bits(NUM_CH)-1:0]   canal,
    output logic                              medida_valida,
    output logic                              erro,
    output logic                              pronto,
    output logic                              ocupado,
    output logic [DB_W-1:0]                   db_estado
);

    localparam int CH_W  = largura_bits(NUM_CH);
    localparam int PS_W  = largura_bits(CM_CYCLES);
    // One shared timer covers trigger width, inter-trigger gap and the watchdog.
    localparam int TMR_W = largura_bits(maior(maior(TRIG_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES) + 1);
    localparam logic [CH_W-1:0] ULTIMO = CH_W'(NUM_CH - 1);

    estado_t             estado, estado_prox;
    logic [CH_W-1:0]     ch;
    logic [TMR_W-1:0]    timer;
    logic [PS_W-1:0]     ps;
    logic [NUM_CH-1:0]   eco_s1, eco_s2, eco_s3;
    logic                eco_atual, echo_sobe, echo_desce;
    logic                conta, cm_fim;
    logic                tempo_esgotado, por_tempo;
    logic [4*DIGITS-1:0] bcd_q;

    // Two-flop synchroniser plus one history flop; both edges see the same delay.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            eco_s1 <= '0;
            eco_s2 <= '0;
            eco_s3 <= '0;
        end else begin
            eco_s1 <= echo;
            eco_s2 <= eco_s1;
            eco_s3 <= eco_s2;
        end
    end

    assign eco_atual  = eco_s2[ch];
    assign echo_sobe  = eco_s2[ch] & ~eco_s3[ch];
    assign echo_desce = ~eco_s2[ch] & eco_s3[ch];

`ifdef TRENA_TIMEOUT_EN
    assign tempo_esgotado = ((estado == ESPERA_ECHO) || (estado == MEDE)) &&
                            (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    // Only meaningful on entry to ARMAZENA: from ESPERA_ECHO it is always a timeout,
    // from MEDE it is a timeout unless the echo actually fell.
    assign por_tempo = (estado == ESPERA_ECHO) || !echo_desce;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erro <= 1'b0;
        end else if (estado_prox == ARMAZENA) begin
            erro <= por_tempo;
        end
    end
`else
    assign tempo_esgotado = 1'b0;
    assign por_tempo      = 1'b0;
    assign erro           = 1'b0;
`endif

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:      if (mensurar) estado_prox = PREPARA;
            PREPARA:     estado_prox = DISPARA;
            DISPARA:     if (timer == TMR_W'(TRIG_CYCLES - 1)) estado_prox = ESPERA_ECHO;
            ESPERA_ECHO: begin
                if (echo_sobe)           estado_prox = MEDE;
                else if (tempo_esgotado) estado_prox = ARMAZENA;
            end
            MEDE:        if (echo_desce || tempo_esgotado) estado_prox = ARMAZENA;
            ARMAZENA:    estado_prox = (ch == ULTIMO) ? FIM : INTERVALO;
            INTERVALO:   if (timer == TMR_W'(GAP_CYCLES - 1)) estado_prox = PREPARA;
            FIM:         estado_prox = continuo ? INTERVALO : OCIOSO;
            default:     estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            ch     <= '0;
            timer  <= '0;
        end else begin
            estado <= estado_prox;
            // Timer restarts on every state change, so each state times itself from entry.
            if ((estado_prox != estado) || (estado == OCIOSO)) timer <= '0;
            else                                              timer <= timer + 1'b1;
            if ((estado == OCIOSO) || (estado == FIM))        ch <= '0;
            else if ((estado == ARMAZENA) && (ch != ULTIMO))  ch <= ch + 1'b1;
        end
    end

    // The rising-edge cycle itself carries echo-high time, so it is counted too.
    assign conta  = ((estado == MEDE) && eco_atual) || ((estado == ESPERA_ECHO) && echo_sobe);
    assign cm_fim = (ps == PS_W'(CM_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps <= '0;
        end else if (estado == PREPARA) begin
            ps <= '0;
        end else if (conta) begin
            ps <= cm_fim ? '0 : ps + 1'b1;
        end
    end

    bcd_contador_sat #(.DIGITS(DIGITS)) u_bcd (
        .clock    (clock),
        .reset    (reset),
        .limpa    (estado == PREPARA),
        .habilita (conta && cm_fim),
        .contagem (bcd_q)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            medida        <= '0;
            canal         <= '0;
            medida_valida <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            medida_valida <= (estado_prox == ARMAZENA);
            pronto        <= (estado_prox == FIM);
            if (estado_prox == ARMAZENA) begin
                medida <= por_tempo ? '0 : bcd_q;
                canal  <= ch;
            end
        end
    end

    always_comb begin
        trigger = '0;
        if (estado == DISPARA) trigger[ch] = 1'b1;
    end

    assign ocupado   = (estado != OCIOSO);
    assign db_estado = estado;

endmodule
